// File: rtl/status_reporter.sv
// status_reporter
// Host-bound telemetry packetiser. Counts completed phase frames and rising
// edges of the receiver read-error level, and on a host request emits a fixed
// 6-byte status packet into the TX FIFO:
//   b0 MAGIC, b1 {mod_enable, 0, mod_half_period}, b2 frame_cnt[15:8],
//   b3 frame_cnt[7:0], b4 err_cnt, b5 XOR(b0..b4)
//
// FIFO handshake: txfifo_full acts as an inverted ready. A byte transfers on
// every cycle in which txfifo_wr is high. txfifo_wr is only ever raised while
// txfifo_full is low, so a write never lands on a full FIFO. While the FIFO is
// full, the current byte is held and re-presented until it can be written.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   report_req         single-cycle host request pulse
//   frame_done         single-cycle pulse per completed phase frame
//   read_error         error level; rising edges are counted (saturating)
//   mod_enable         modulation enable, snapshotted at accept
//   mod_half_period    modulation half period, snapshotted at accept
//   txfifo_full        TX FIFO full
//   txfifo_wr          TX FIFO write strobe
//   txfifo_data        TX FIFO write data
//   busy               packet in progress (FSM is in SEND)
//   dropped_req        one-cycle pulse after a request arrives during SEND
module status_reporter #(
  parameter int          DATA_W        = 8,
  parameter logic [7:0]  MAGIC         = 8'hA5,
  parameter bit          CLEAR_ON_READ = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              report_req,
  input  logic              frame_done,
  input  logic              read_error,
  input  logic              mod_enable,
  input  logic [5:0]        mod_half_period,
  input  logic              txfifo_full,
  output logic              txfifo_wr,
  output logic [DATA_W-1:0] txfifo_data,
  output logic              busy,
  output logic              dropped_req
);

  if (DATA_W != 8) begin : g_bad_width
    $error("status_reporter: DATA_W must be 8");
  end

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic        prev;
  logic [15:0] sh_frame;
  logic [7:0]  sh_err;
  logic        sh_en;
  logic [5:0]  sh_hp;
  logic [7:0]  byte_sel;
  logic        err_edge;
  logic        accept;
  logic        write;

  assign err_edge = read_error & ~prev;
  assign accept   = (state == IDLE) & report_req;
  // Reset is folded in combinationally so a packet aborted by reset produces
  // no write even in the reset cycle itself.
  assign write    = (state == SEND) & ~txfifo_full & ~rst;
  assign busy     = (state == SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 3'd0;
      frame_cnt   <= 16'd0;
      err_cnt     <= 8'd0;
      prev        <= 1'b0;
      sh_frame    <= 16'd0;
      sh_err      <= 8'd0;
      sh_en       <= 1'b0;
      sh_hp       <= 6'd0;
      dropped_req <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      prev        <= read_error;
      dropped_req <= (state == SEND) & report_req;
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      // Clearing at accept keeps an error edge from the accept cycle itself,
      // since the snapshot holds only the pre-increment value.
      if (accept && CLEAR_ON_READ) begin
        err_cnt <= {7'd0, err_edge};
      end else if (err_edge && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (accept) begin
        sh_frame <= frame_cnt;
        sh_err   <= err_cnt;
        sh_en    <= mod_enable;
        sh_hp    <= mod_half_period;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (report_req) begin
          state_nx = SEND;
          idx_nx   = 3'd0;
        end
      end
      SEND: begin
        if (write) begin
          if (idx == 3'd5) begin
            state_nx = IDLE;
            idx_nx   = 3'd0;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 3'd0;
      end
    endcase
  end

  always_comb begin
    byte_sel = 8'd0;
    case (idx)
      3'd0: byte_sel = MAGIC;
      3'd1: byte_sel = {sh_en, 1'b0, sh_hp};
      3'd2: byte_sel = sh_frame[15:8];
      3'd3: byte_sel = sh_frame[7:0];
      3'd4: byte_sel = sh_err;
      3'd5: byte_sel = MAGIC ^ {sh_en, 1'b0, sh_hp} ^ sh_frame[15:8]
                       ^ sh_frame[7:0] ^ sh_err;
      default: byte_sel = 8'd0;
    endcase
  end

  assign txfifo_wr   = write;
  assign txfifo_data = ((state == SEND) && !rst) ? byte_sel : 8'd0;

endmodule

// File: tb/tb_status_reporter.sv
// Testbench for status_reporter: drives frame/error/request stimulus, keeps a
// small model of the counters, and compares every FIFO write against the
// expected byte queue.
module tb_status_reporter;

  localparam logic [7:0] MAGIC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       report_req;
  logic       frame_done;
  logic       read_error;
  logic       mod_enable;
  logic [5:0] mod_half_period;
  logic       txfifo_full;
  logic       txfifo_wr;
  logic [7:0] txfifo_data;
  logic       busy;
  logic       dropped_req;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int m_frame;
  int m_err;
  logic [7:0] got_exp;

  status_reporter #(.DATA_W(8), .MAGIC(MAGIC), .CLEAR_ON_READ(1'b1)) dut (
    .clk(clk), .rst(rst), .report_req(report_req), .frame_done(frame_done),
    .read_error(read_error), .mod_enable(mod_enable),
    .mod_half_period(mod_half_period), .txfifo_full(txfifo_full),
    .txfifo_wr(txfifo_wr), .txfifo_data(txfifo_data), .busy(busy),
    .dropped_req(dropped_req)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (txfifo_wr === 1'b1) begin
      total++;
      if (txfifo_full !== 1'b0) begin
        bad++;
        $display("FAIL wr_under_full wr=%b full=%b", txfifo_wr, txfifo_full);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%02h exp=none", txfifo_data);
      end else begin
        got_exp = exp_q.pop_front();
        if (txfifo_data !== got_exp) begin
          bad++;
          $display("FAIL packet_byte got=%02h exp=%02h", txfifo_data, got_exp);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_done = 1'b1;
      step();
    end
    frame_done = 1'b0;
    m_frame = (m_frame + n) % 65536;
  endtask

  task automatic error_edges(input int n);
    for (int i = 0; i < n; i++) begin
      read_error = 1'b1;
      step();
      read_error = 1'b0;
      step();
    end
    m_err = (m_err + n > 255) ? 255 : m_err + n;
  endtask

  task automatic push_packet(input logic en, input logic [5:0] hp,
                             input logic [15:0] fc, input logic [7:0] ec);
    logic [7:0] b[6];
    b[0] = MAGIC;
    b[1] = {en, 1'b0, hp};
    b[2] = fc[15:8];
    b[3] = fc[7:0];
    b[4] = ec;
    b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
    for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
  endtask

  // Request accepted from IDLE; optional frame/error event in the same cycle.
  task automatic request(input bit with_frame, input bit with_err);
    logic [15:0] fc;
    logic [7:0]  ec;
    fc = m_frame[15:0];
    ec = m_err[7:0];
    report_req = 1'b1;
    frame_done = with_frame;
    read_error = with_err;
    push_packet(mod_enable, mod_half_period, fc, ec);
    m_frame = (m_frame + int'(with_frame)) % 65536;
    m_err   = with_err ? 1 : 0;
    step();
    report_req = 1'b0;
    frame_done = 1'b0;
    read_error = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_timeout busy=%b exp=0", busy);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained left=%0d exp=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    m_frame = 0;
    m_err = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    read_error = 1'b1;
    do_reset();
    total++;
    if (txfifo_wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", txfifo_wr); end
    total++;
    if (txfifo_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%02h exp=00", txfifo_data); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++;
    if (dropped_req !== 1'b0) begin bad++; $display("FAIL rst_dropped got=%b exp=0", dropped_req); end
    // read_error held through reset counts once afterwards
    step();
    read_error = 1'b0;
    m_err = 1;
    step();
    mod_enable = 1'b0;
    mod_half_period = 6'd5;
    request(0, 0);
    wait_idle();
    check_drained("reset");
  endtask

  task automatic test_basic();
    pulse_frames(3);
    error_edges(2);
    mod_enable = 1'b1;
    mod_half_period = 6'd10;
    request(0, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || txfifo_wr !== 1'b1) begin
        bad++;
        $display("FAIL basic_cycle%0d busy=%b wr=%b exp=1/1", k, busy, txfifo_wr);
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
    check_drained("basic");
  endtask

  task automatic test_back_to_back();
    // still in cycle t+7 of the previous packet: accept immediately
    request(0, 0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_idle();
    check_drained("b2b");
  endtask

  task automatic test_backpressure();
    mod_enable = 1'b0;
    mod_half_period = 6'd33;
    request(0, 0);
    @(negedge clk);
    @(negedge clk);
    step();
    txfifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (txfifo_wr !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d wr=%b busy=%b exp=0/1", k, txfifo_wr, busy);
      end
      step();
    end
    txfifo_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (txfifo_wr !== 1'b1) begin bad++; $display("FAIL bp_write%0d wr=%b exp=1", k, txfifo_wr); end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_fall got=%b exp=0", busy); end
    check_drained("bp");
  endtask

  task automatic test_toggle();
    mod_enable = 1'($urandom_range(0, 1));
    mod_half_period = 6'($urandom_range(0, 63));
    pulse_frames($urandom_range(1, 20));
    request(0, 0);
    for (int k = 0; k < 20; k++) begin
      txfifo_full = ~txfifo_full;
      step();
    end
    txfifo_full = 1'b0;
    wait_idle();
    check_drained("toggle");
  endtask

  task automatic test_wrap();
    do_reset();
    pulse_frames(65535);
    request(1, 0);
    wait_idle();
    check_drained("wrap_ffff");
    request(0, 0);
    wait_idle();
    check_drained("wrap_zero");
  endtask

  task automatic test_saturate();
    error_edges(300);
    request(0, 1);
    wait_idle();
    check_drained("sat_ff");
    request(0, 0);
    wait_idle();
    check_drained("sat_one");
  endtask

  task automatic test_dropped();
    request(0, 0);
    step();
    step();
    step();
    report_req = 1'b1;
    @(negedge clk);
    total++;
    if (dropped_req !== 1'b0) begin bad++; $display("FAIL drop_early got=%b exp=0", dropped_req); end
    step();
    report_req = 1'b0;
    @(negedge clk);
    total++;
    if (dropped_req !== 1'b1) begin bad++; $display("FAIL drop_pulse got=%b exp=1", dropped_req); end
    @(negedge clk);
    total++;
    if (dropped_req !== 1'b0) begin bad++; $display("FAIL drop_len got=%b exp=0", dropped_req); end
    wait_idle();
    for (int k = 0; k < 10; k++) step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL drop_no_second got=%b exp=0", busy); end
    check_drained("drop");
  endtask

  task automatic test_reset_mid();
    pulse_frames(7);
    request(0, 0);
    step();
    step();
    step();
    rst = 1'b1;
    exp_q.delete();
    m_frame = 0;
    m_err = 0;
    @(negedge clk);
    total++;
    if (txfifo_wr !== 1'b0) begin bad++; $display("FAIL rmid_wr got=%b exp=0", txfifo_wr); end
    step();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    step();
    request(0, 0);
    wait_idle();
    check_drained("rmid");
  endtask

  initial begin
    rst = 1'b1;
    report_req = 1'b0;
    frame_done = 1'b0;
    read_error = 1'b0;
    mod_enable = 1'b0;
    mod_half_period = 6'd0;
    txfifo_full = 1'b0;
    m_frame = 0;
    m_err = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_toggle();
    test_saturate();
    test_dropped();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
